gauss3x3_conv_pipe: RTL

- Parametrised, pipelined successor to the combinational 3x3 Gaussian computing block.
- Accepts one 3x3 pixel window per cycle with a border type. Applies a runtime-programmable 9-tap kernel with per-border tap masking, sums, normalises by a runtime shift, saturates, and emits one filtered pixel.
- Sits between the line-buffer/window generator and the output writer.
- Uses a valid/ready handshake on both sides so downstream backpressure stalls the window generator without data loss.

---
 rtl/gauss3x3_conv_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gauss3x3_conv_pipe.sv
// gauss3x3_conv_pipe
// ------------------
// A pipelined 3x3 convolution stage that sits between the window generator
// and the output writer. It accepts one 3x3 window per cycle. The window
// carries a border class (corner_type), which masks off the taps that fall
// outside the image. Each enabled tap is multiplied by a runtime-programmable
// coefficient. The products are summed and normalised by a runtime right
// shift, and the result is saturated to the pixel width.
//
// Pipeline (3 cycles from input transfer to out_valid):
//   S1: masked tap products plus the sample's shift amount
//   S2: three row sums
//   S3: total, shift, saturate -> data_out / out_valid
// All stages advance together. They advance when the output register is
// empty or is being drained (adv = !out_valid || out_ready).
//
// Optional build macro GAUSS_CONV_ROUND_EN: when defined, the normaliser
// rounds half-up before the shift. Otherwise it truncates.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        window/corner_type/cfg_shift valid
//   in_ready        block accepts a window this cycle
//   win_data        9 taps, tap k = r*3+c at [k*DATA_WIDTH +: DATA_WIDTH]
//   corner_type     border class of the window
//   cfg_shift       normalisation right shift, sampled with the window
//   coef_wr_en      coefficient write strobe
//   coef_wr_addr    coefficient index 0..8 (9..15 ignored)
//   coef_wr_data    coefficient value
//   out_valid       data_out valid
//   out_ready       downstream accepts data_out
//   data_out        filtered pixel
module gauss3x3_conv_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [9*DATA_WIDTH-1:0] win_data,
  input  logic [3:0]              corner_type,
  input  logic [3:0]              cfg_shift,
  input  logic                    coef_wr_en,
  input  logic [3:0]              coef_wr_addr,
  input  logic [COEF_WIDTH-1:0]   coef_wr_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

  logic                  adv;
  logic [COEF_WIDTH-1:0] coef [9];
  logic [8:0]            tap_mask;
  logic [PROD_WIDTH-1:0] prod_next [9];

  logic                  s1_valid;
  logic [PROD_WIDTH-1:0] s1_prod [9];
  logic [3:0]            s1_shift;

  logic                  s2_valid;
  logic [ACC_WIDTH-1:0]  s2_row [3];
  logic [3:0]            s2_shift;

  logic [ACC_WIDTH-1:0]  total;
  logic [ACC_WIDTH:0]    res;
  logic [DATA_WIDTH-1:0] sat;

  // The default kernel is the classic 1-2-1 / 2-4-2 / 1-2-1 Gaussian.
  function automatic logic [COEF_WIDTH-1:0] default_coef(input int k);
    if (k == 4)          return COEF_WIDTH'(4);
    else if (k % 2 == 1) return COEF_WIDTH'(2);
    else                 return COEF_WIDTH'(1);
  endfunction

  // A single advance signal stalls every stage at once. A stalled output
  // therefore never loses data, and the window generator is held off
  // through in_ready.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // The coefficient bank is written regardless of stall. Out-of-range
  // addresses are dropped. A window accepted on the same edge reads the old
  // value, because S1 samples coef before this register updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) coef[k] <= default_coef(k);
    end else if (coef_wr_en && coef_wr_addr < 4'd9) begin
      coef[coef_wr_addr] <= coef_wr_data;
    end
  end

  // Each border class enables the taps that lie inside the image.
  // Class 0 disables everything, so the output is 0. Classes 7..15 are
  // interior windows.
  always_comb begin
    tap_mask = 9'h1ff;
    case (corner_type)
      4'd0:    tap_mask = 9'b000_000_000;
      4'd1:    tap_mask = 9'b000_011_011;
      4'd2:    tap_mask = 9'b000_110_110;
      4'd3:    tap_mask = 9'b011_011_011;
      4'd4:    tap_mask = 9'b110_110_110;
      4'd5:    tap_mask = 9'b011_011_000;
      4'd6:    tap_mask = 9'b110_110_000;
      default: tap_mask = 9'h1ff;
    endcase
  end

  // Full-width products of tap and coefficient. A masked tap contributes 0.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_next[k] = '0;
      if (tap_mask[k])
        prod_next[k] = PROD_WIDTH'(win_data[k*DATA_WIDTH +: DATA_WIDTH]) *
                       PROD_WIDTH'(coef[k]);
    end
  end

  // The final adder tree and the normaliser. When rounding is enabled, half
  // an LSB of the shifted result is added first. A zero shift passes the
  // total straight through. Saturation looks only at the shifted value.
  always_comb begin
    total = s2_row[0] + s2_row[1] + s2_row[2];
`ifdef GAUSS_CONV_ROUND_EN
    if (s2_shift != 4'd0)
      res = ({1'b0, total} + ((ACC_WIDTH+1)'(1) << (s2_shift - 4'd1))) >> s2_shift;
    else
      res = {1'b0, total};
`else
    res = {1'b0, total} >> s2_shift;
`endif
    if (|res[ACC_WIDTH:DATA_WIDTH]) sat = '1;
    else                            sat = res[DATA_WIDTH-1:0];
  end

  // The three pipeline stages share a single advance. Reset clears every
  // valid flag, so in-flight samples are simply forgotten. data_out is
  // loaded only by real samples, which keeps it quiet during bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      s1_shift  <= '0;
      s2_shift  <= '0;
      for (int k = 0; k < 9; k++) s1_prod[k] <= '0;
      for (int r = 0; r < 3; r++) s2_row[r] <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_prod  <= prod_next;
      s1_shift <= cfg_shift;

      s2_valid <= s1_valid;
      s2_shift <= s1_shift;
      for (int r = 0; r < 3; r++)
        s2_row[r] <= ACC_WIDTH'(s1_prod[3*r]) + ACC_WIDTH'(s1_prod[3*r+1]) +
                     ACC_WIDTH'(s1_prod[3*r+2]);

      out_valid <= s2_valid;
      if (s2_valid) data_out <= sat;
    end
  end

endmodule
